rr_arb4: RTL and testbench

RR_ARB4 -- requirements
Module: rr_arb4

---
 rtl/rr_arb4.sv | 118 +++++++++++
 tb/tb_rr_arb4.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter with a registered one-hot grant, a per-owner
// hold limit (MAX_HOLD), enable-driven revoke and a forced-release timeout pulse.
module rr_arb4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    logic [0:0] state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic       timeout_q, timeout_d;

    logic [2:0] win_idle, win_rel;
    logic [1:0] ptr_rel;

    // Returns {found, index} of the first set request searching p, p+1, ... mod 4.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        gnt_id_d  = gnt_id_q;
        timeout_d = 1'b0;

        // Releasing owner goes to the back of the queue, so a forced owner
        // only wins again when nobody else is waiting.
        ptr_rel  = gnt_id_q + 2'd1;
        win_idle = pick(req, ptr_q);
        win_rel  = pick(req, ptr_rel);

        case (state_q)
            ST_IDLE: begin
                if (en && win_idle[2]) begin
                    state_d  = ST_GRANT;
                    grant_d  = 4'b0001 << win_idle[1:0];
                    gnt_id_d = win_idle[1:0];
                    hold_d   = 8'd1;
                end
            end
            ST_GRANT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    grant_d = 4'b0000;
                    ptr_d   = ptr_rel;
                    hold_d  = 8'd0;
                end else if (req[gnt_id_q] && hold_q < HOLD_MAX) begin
                    hold_d = hold_q + 8'd1;
                end else begin
                    ptr_d     = ptr_rel;
                    timeout_d = req[gnt_id_q];
                    if (win_rel[2]) begin
                        grant_d  = 4'b0001 << win_rel[1:0];
                        gnt_id_d = win_rel[1:0];
                        hold_d   = 8'd1;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = 4'b0000;
                        hold_d  = 8'd0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
                hold_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            hold_q    <= 8'd0;
            grant_q   <= 4'b0000;
            gnt_id_q  <= 2'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            gnt_id_q  <= gnt_id_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant   = grant_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = (state_q == ST_GRANT);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Bench for rr_arb4: directed scenarios with literal expectations plus a
// cycle-by-cycle reference model for MAX_HOLD=8 and MAX_HOLD=1 instances.
module tb_rr_arb4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req;

    logic [3:0] g0, g1;
    logic [1:0] id0, id1;
    logic       b0, b1, t0, t1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rr_arb4 #(.MAX_HOLD(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .grant(g0), .gnt_id(id0), .busy(b0), .timeout(t0)
    );

    rr_arb4 #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .grant(g1), .gnt_id(id1), .busy(b1), .timeout(t1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner (-1 = nobody), search start, cycles held, last id, pulse.
    int m_own[2], m_ptr[2], m_hold[2], m_gid[2], m_tmo[2];

    function automatic int first_req(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic mreset(input int i);
        m_own[i] = -1; m_ptr[i] = 0; m_hold[i] = 0; m_gid[i] = 0; m_tmo[i] = 0;
    endtask

    task automatic mstep(input int i, input int mh);
        int o;
        o = m_own[i];
        m_tmo[i] = 0;
        if (o < 0) begin
            if (en && req != 4'b0000) begin
                m_own[i] = first_req(req, m_ptr[i]);
                m_gid[i] = m_own[i];
                m_hold[i] = 1;
            end
        end else if (!en) begin
            m_ptr[i] = (o + 1) % 4;
            m_own[i] = -1;
            m_hold[i] = 0;
        end else if (req[o] && m_hold[i] < mh) begin
            m_hold[i]++;
        end else begin
            m_tmo[i] = req[o] ? 1 : 0;
            m_ptr[i] = (o + 1) % 4;
            m_own[i] = first_req(req, m_ptr[i]);
            if (m_own[i] >= 0) begin
                m_gid[i] = m_own[i];
                m_hold[i] = 1;
            end else begin
                m_hold[i] = 0;
            end
        end
    endtask

    function automatic logic [7:0] mexp(input int i);
        logic [3:0] g;
        g = (m_own[i] < 0) ? 4'b0000 : 4'(1 << m_own[i]);
        return {g, 2'(m_gid[i]), (m_own[i] >= 0), 1'(m_tmo[i])};
    endfunction

    initial begin
        mreset(0); mreset(1);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mreset(0); mreset(1);
                #1;
            end else begin
                #1;
                mstep(0, 8); mstep(1, 1);
            end
            chk("model_dut0", {24'd0, g0, id0, b0, t0}, {24'd0, mexp(0)});
            chk("model_dut1", {24'd0, g1, id1, b1, t1}, {24'd0, mexp(1)});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; req = 4'b1111;
        #1;
        chk("rst_grant", 32'(g0), 32'h0);
        chk("rst_gnt_id", 32'(id0), 32'h0);
        chk("rst_busy", 32'(b0), 32'h0);
        chk("rst_timeout", 32'(t0), 32'h0);

        @(negedge clk); rst_n = 1'b1; req = 4'b0101;
        @(negedge clk);
        chk("handoff_first", 32'({g0, id0}), 32'({4'b0001, 2'd0}));
        req = 4'b0100;
        @(negedge clk);
        chk("handoff_second", 32'({g0, id0, b0}), 32'({4'b0100, 2'd2, 1'b1}));

        en = 1'b0;
        @(negedge clk);
        chk("revoke", 32'({g0, b0, t0}), 32'h0);
        en = 1'b1; req = 4'b1100;
        @(negedge clk);
        chk("revoke_ptr3", 32'({g0, id0}), 32'({4'b1000, 2'd3}));

        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mid", 32'({g0, b0, g1, b1}), 32'h0);
        rst_n = 1'b1; req = 4'b1001;
        @(negedge clk);
        chk("after_rst_ptr0", 32'(g0), 32'h1);

        // Fairness with all four requesting; dut1 rotates every cycle.
        rst_n = 1'b0; req = 4'b1111;
        @(negedge clk); rst_n = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            chk("fair_grant", 32'(g0), 32'(1 << (((k - 1) / 8) % 4)));
            chk("fair_id", 32'(id0), 32'(((k - 1) / 8) % 4));
            chk("fair_timeout", 32'(t0), 32'((k > 1) && ((k - 1) % 8 == 0)));
            chk("mh1_grant", 32'(g1), 32'(1 << ((k - 1) % 4)));
            chk("mh1_timeout", 32'(t1), 32'(k > 1));
        end

        req = 4'b0010;
        for (int j = 1; j <= 24; j++) begin
            @(negedge clk);
            chk("lone_grant", 32'({g0, id0}), 32'({4'b0010, 2'd1}));
            chk("lone_timeout", 32'(t0), 32'((j > 1) && ((j - 1) % 8 == 0)));
        end
        // hold count is at MAX_HOLD here: revoke must win over the forced release
        en = 1'b0;
        @(negedge clk);
        chk("revoke_at_max", 32'({g0, b0, t0}), 32'h0);

        for (int n = 0; n < 150; n++) begin
            en  = ($urandom_range(0, 9) != 0);
            req = 4'($urandom_range(0, 15));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
